// File: rtl/spike_rate_decoder.sv
// Spike-train decoder: counts spikes and the latest inter-spike interval over a
// programmable window, presenting each window's result on a valid/ready port.
module spike_rate_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_in,
  input  logic             enable,
  input  logic [CNT_W-1:0] window_len,
  output logic [CNT_W-1:0] rate_out,
  output logic [CNT_W-1:0] isi_out,
  output logic             missed_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_HOLD} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_len, r_cyc, r_spk, r_tmr, r_last_isi;
  logic             r_seen, r_missed;
  logic [CNT_W-1:0] r_rate, r_isi, r_p_rate, r_p_isi;
  logic             r_miss_o, r_p_miss, r_valid;

  logic [CNT_W-1:0] w_spk_n, w_tmr_inc, w_last_n;
  logic             w_end, w_go, w_start, w_load_new, w_load_pend, w_store_pend;

  // Next-cycle counter values; a window-end result is taken from these so the
  // closing edge's own sample is included.
  assign w_tmr_inc = (r_tmr == MAX) ? MAX : r_tmr + 1'b1;
  assign w_spk_n   = (spike_in && r_spk != MAX) ? r_spk + 1'b1 : r_spk;
  assign w_last_n  = (spike_in && r_seen) ? w_tmr_inc : r_last_isi;
  assign w_end     = (r_state == S_COUNT) && (r_cyc == r_len - 1'b1);
  assign w_go      = enable && (window_len != '0);

  always_comb begin
    w_state_n    = r_state;
    w_start      = 1'b0;
    w_load_new   = 1'b0;
    w_load_pend  = 1'b0;
    w_store_pend = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_start   = 1'b1;
          w_state_n = S_COUNT;
        end
      end
      S_COUNT: begin
        if (w_end) begin
          if (!r_valid || out_ready) begin
            w_load_new = 1'b1;
            w_start    = w_go;
            w_state_n  = w_go ? S_COUNT : S_IDLE;
          end else begin
            w_store_pend = 1'b1;
            w_state_n    = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (out_ready) begin
          w_load_pend = 1'b1;
          w_start     = w_go;
          w_state_n   = w_go ? S_COUNT : S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_len      <= '0;
      r_cyc      <= '0;
      r_spk      <= '0;
      r_tmr      <= '0;
      r_last_isi <= '0;
      r_seen     <= 1'b0;
      r_missed   <= 1'b0;
      r_rate     <= '0;
      r_isi      <= '0;
      r_miss_o   <= 1'b0;
      r_p_rate   <= '0;
      r_p_isi    <= '0;
      r_p_miss   <= 1'b0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_state_n;

      if (w_load_new || w_load_pend) r_valid <= 1'b1;
      else if (r_valid && out_ready) r_valid <= 1'b0;

      if (w_load_new) begin
        r_rate   <= w_spk_n;
        r_isi    <= w_last_n;
        r_miss_o <= r_missed;
      end else if (w_load_pend) begin
        r_rate   <= r_p_rate;
        r_isi    <= r_p_isi;
        r_miss_o <= r_p_miss;
      end

      if (w_store_pend) begin
        r_p_rate <= w_spk_n;
        r_p_isi  <= w_last_n;
        r_p_miss <= r_missed;
      end

      if (w_load_new || w_store_pend) r_missed <= 1'b0;
      else if (r_state == S_HOLD && spike_in) r_missed <= 1'b1;

      // A restart wins over the final count update: the result already took it.
      if (w_start) begin
        r_len      <= window_len;
        r_cyc      <= '0;
        r_spk      <= '0;
        r_tmr      <= '0;
        r_last_isi <= '0;
        r_seen     <= 1'b0;
      end else if (r_state == S_COUNT) begin
        r_spk      <= w_spk_n;
        r_tmr      <= spike_in ? '0 : w_tmr_inc;
        r_last_isi <= w_last_n;
        r_seen     <= r_seen | spike_in;
        r_cyc      <= r_cyc + 1'b1;
      end
    end
  end

  assign rate_out   = r_rate;
  assign isi_out    = r_isi;
  assign missed_out = r_miss_o;
  assign out_valid  = r_valid;
  assign busy       = (r_state != S_IDLE);
endmodule

// File: doc/spike_rate_decoder.md
Name: spike_rate_decoder

Overview:
- Receiver-side counterpart to the LIF neuron: it turns a 1-bit spike train back into numeric values.
- Over a programmable window of L clock cycles it measures:
  - the spike count (rate estimate);
  - the most recent inter-spike interval (ISI).
- Each window's result is presented on an 8-bit valid/ready output with one pending-result buffer.
- Sits downstream of an LIF spike output, for readout or for feeding another neuron's current input.

Parameters:
- CNT_W, 8, width of the spike count, ISI and window counters; all saturate at 2^CNT_W-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- spike_in  input  1  spike sample, one per cycle
- enable  input  1  start a window, or continue back-to-back windows
- window_len  input  CNT_W  window length L in cycles; sampled only at window start; 0 = do not start
- rate_out  output  CNT_W  spikes in window, saturating
- isi_out  output  CNT_W  cycles between the last two spikes in window; 0 if fewer than 2 spikes
- missed_out  output  1  spikes were dropped in HOLD before this window started
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts the result
- busy  output  1  state is COUNT or HOLD

Behaviour:
- Reset (any cycle, including mid-window or mid-HOLD):
  - state=IDLE;
  - all counters, output registers and the pending register cleared;
  - out_valid=0, missed flag=0, busy=0.
- States: IDLE, COUNT, HOLD.
- IDLE:
  - At an edge with enable=1 and window_len!=0: latch L=window_len, clear cyc/spk/isi counters and last_isi, go to COUNT.
  - The first spike sampled is the one at the next edge.
  - Otherwise stay in IDLE.
- COUNT, at each edge:
  - spk += spike_in, saturating.
  - isi_timer increments, saturating.
  - On spike_in=1:
    - if a prior spike was seen in this window, last_isi = isi_timer+1 (saturating);
    - isi_timer is then cleared.
  - Spikes on consecutive cycles give ISI=1.
  - cyc increments.
- Window end:
  - The window closes at the edge where cyc==L-1, so exactly L spike samples are taken, including that edge's sample.
  - Result = {spk final, last_isi final, missed flag}.
  - The missed flag is cleared once it is captured into a result.
- Result load at window end:
  - If out_valid=0, or out_valid=1 and out_ready=1 in the same cycle: load the output registers and set out_valid=1 (it stays 1 for a simultaneous accept-and-load).
  - Otherwise: store the result in the pending register and go to HOLD.
- After a load:
  - enable=1: restart COUNT immediately with a freshly sampled window_len (0 → IDLE). There is no gap cycle.
  - enable=0: go to IDLE.
- Latency: out_valid rises on the edge that samples the last spike of the window.
- HOLD:
  - No counting takes place.
  - Any spike_in=1 sets the sticky missed flag.
  - At an edge with out_ready=1: the output registers take the pending value, out_valid stays 1, then the same enable/window_len rule applies.
- Output handshake:
  - A transfer occurs at an edge where out_valid && out_ready.
  - rate_out, isi_out and missed_out are stable while out_valid=1 and not accepted.
  - If nothing new is loaded, out_valid falls after the transfer.
- Deasserting enable mid-COUNT does not abort the window; it only prevents the restart.
- Changes to window_len mid-window are ignored.
- Saturation:
  - spk, isi_timer and last_isi never wrap; they hold at 255 when CNT_W=8.
  - L=255 with spike_in=1 every cycle gives rate_out=255.

Test Plan:
- Reset, enable=1, L=10, spikes at window cycles 2,5,9 (1-based); out_ready=1 → out_valid rises after the 10th sample with rate_out=3, isi_out=4, missed_out=0.
- L=4, spike_in=1 continuously, enable=1, out_ready=1 → back-to-back results every 4 cycles with rate=4, isi=1, no idle cycles between windows.
- L=255, spike_in=1 continuously; separately L=200 with one spike per window → rate_out saturates at 255; isi_out=0 when there is a single spike.
- L=3, out_ready=0 for 8 cycles while spikes continue → first result held stable, FSM in HOLD, busy=1; after out_ready pulses, the next window's result reports missed_out=1.
- enable=0 asserted mid-window, L=6, 2 spikes → window completes, rate_out=2, FSM returns to IDLE, busy=0; L=0 with enable=1 → stays in IDLE.
- reset asserted mid-COUNT and again in HOLD → next cycle out_valid=0, busy=0, outputs 0; a subsequent window counts from 0.
